spram_word_port: RTL

Request sequencer that sits directly upstream of the byte-addressable SPRAM block. It accepts byte, halfword and word load/store requests from the CPU over a valid/ready handshake and breaks each one into single-byte SPRAM accesses. It assembles little-endian read data with optional sign extension and signals completion with a one-cycle response pulse.

---
 rtl/spram_word_port.sv | 90 +++++++++
 1 files changed

// File: rtl/spram_word_port.sv
// spram_word_port: splits CPU byte/halfword/word load-store requests into single-byte SPRAM accesses
module spram_word_port #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_t;
    state_t      state, state_nx;
    logic [1:0]  idx, last, nidx;
    logic        sgn, last_byte;
    logic [31:0] wdat, rbuf, merged, extended;
    assign nidx       = idx + 2'd1;
    assign last_byte  = idx == last;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign ram_wen    = state == WR;
    // next-state decode; RD_DATA loops back to RD_ADDR until the final byte
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_write ? WR : RD_ADDR;
            WR:      if (last_byte) state_nx = RESP;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = last_byte ? RESP : RD_ADDR;
            default: state_nx = IDLE;
        endcase
    end
    // insert the incoming read byte and apply zero/sign extension by size
    always_comb begin
        merged = rbuf;
        merged[{idx, 3'b000} +: 8] = ram_rdata;
        extended = last == 2'd0 ? {{24{sgn & merged[7]}}, merged[7:0]} :
                   last == 2'd1 ? {{16{sgn & merged[15]}}, merged[15:0]} : merged;
    end
    // state, request latch and registered SPRAM address/data; ram_addr stays put through RD_DATA
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= 2'd0;
            last       <= 2'd0;
            sgn        <= 1'b0;
            wdat       <= 32'd0;
            rbuf       <= 32'd0;
            resp_rdata <= 32'd0;
            ram_addr   <= '0;
            ram_wdata  <= 8'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    idx       <= 2'd0;
                    last      <= req_size == 2'd0 ? 2'd0 : req_size == 2'd1 ? 2'd1 : 2'd3;
                    sgn       <= req_signed;
                    wdat      <= req_wdata;
                    rbuf      <= 32'd0;
                    ram_addr  <= req_addr;
                    ram_wdata <= req_wdata[7:0];
                end
                WR: if (!last_byte) begin
                    idx       <= nidx;
                    ram_addr  <= ram_addr + 1'b1;
                    ram_wdata <= wdat[{nidx, 3'b000} +: 8];
                end
                RD_DATA: begin
                    rbuf <= merged;
                    if (last_byte) resp_rdata <= extended;
                    else begin
                        idx      <= nidx;
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
